// File: rtl/dmem_byte_bridge_pkg.sv
// ---------------------------------------------------------------------------
// dmem_byte_bridge_pkg
//
// Shared definitions for the data-memory byte bridge:
//   - dmem_state_t : FSM state encodings (DMEM_IDLE/READ/WRITE/DONE)
//   - DMEM_LANES   : byte lanes per word
//   - RstEnable / WriteEnable / ZeroWord : common constants of this codebase
//   - lane_byte()  : extracts one byte lane from a 32-bit word
// ---------------------------------------------------------------------------
package dmem_byte_bridge_pkg;

    localparam int          DMEM_LANES  = 4;
    localparam logic        RstEnable   = 1'b0;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic [1:0] {
        DMEM_IDLE  = 2'b00,
        DMEM_READ  = 2'b01,
        DMEM_WRITE = 2'b10,
        DMEM_DONE  = 2'b11
    } dmem_state_t;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_lane_pick.sv
// ---------------------------------------------------------------------------
// dmem_lane_pick
//
// Combinational next-set-lane finder used when lane skipping is enabled
// (DMEM_WRITE_SKIP_EN). Searches the lane mask for the lowest set lane whose
// index is >= i_from.
//
// Ports:
//   i_mask [DMEM_LANES-1:0] : byte-lane enables
//   i_from [2:0]            : first lane index to consider (4 = past the end)
//   o_lane [1:0]            : lowest set lane at or above i_from
//   o_last                  : 1 when no set lane remains (o_lane is then 0)
// ---------------------------------------------------------------------------
module dmem_lane_pick
    import dmem_byte_bridge_pkg::*;
(
    input  logic [DMEM_LANES-1:0] i_mask,
    input  logic [2:0]            i_from,
    output logic [1:0]            o_lane,
    output logic                  o_last
);

    // Scan from the top down so the lowest qualifying lane is the final winner.
    always_comb begin
        o_lane = 2'd0;
        o_last = 1'b1;
        for (int k = DMEM_LANES - 1; k >= 0; k--) begin
            if (i_mask[k] && (k >= int'(i_from))) begin
                o_lane = 2'(k);
                o_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_byte_bridge.sv
// ---------------------------------------------------------------------------
// dmem_byte_bridge
//
// Serves word-level MEM-stage data requests against a byte-wide synchronous
// external RAM. Reads gather four bytes (little-endian) into rdata_o; writes
// are emitted as per-lane byte strobes. stall_o holds the pipeline until
// ready_o pulses for one cycle.
//
// Optional feature macro: DMEM_WRITE_SKIP_EN
//   defined   : WRITE visits only lanes whose select bit is set
//   undefined : WRITE always walks all four lanes
//
// Ports:
//   clk, rst (async, active-low)
//   req_ce_i, req_we_i, req_addr_i[31:0], req_wdata_i[31:0], req_sel_i[3:0]
//   rdata_o[31:0], ready_o, stall_o
//   ram_a_o[ADDR_WIDTH-1:0], ram_dout_o[7:0], ram_wr_o, ram_din_i[7:0]
// ---------------------------------------------------------------------------
module dmem_byte_bridge
    import dmem_byte_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_ce_i,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_sel_i,
    output logic [31:0]           rdata_o,
    output logic                  ready_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] ram_a_o,
    output logic [7:0]            ram_dout_o,
    output logic                  ram_wr_o,
    input  logic [7:0]            ram_din_i
);

    dmem_state_t           r_state;
    dmem_state_t           w_state_next;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_next;
    logic [ADDR_WIDTH-3:0] r_addr;
    logic [31:0]           r_wdata;
    logic [DMEM_LANES-1:0] r_sel;
    logic [23:0]           r_shadow;
    logic [31:0]           r_rdata;
    logic                  w_is_write_req;
    logic                  w_unused_addr;

    // Word-aligned addressing: the lane bits and the bits beyond the RAM are dropped.
    assign w_unused_addr  = ^{req_addr_i[31:ADDR_WIDTH], req_addr_i[1:0]};
    assign w_is_write_req = (req_we_i == WriteEnable);

`ifdef DMEM_WRITE_SKIP_EN
    logic [DMEM_LANES-1:0] w_pick_mask;
    logic [2:0]            w_pick_from;
    logic [1:0]            w_pick_lane;
    logic                  w_pick_last;

    // In IDLE the picker finds the first lane of the incoming request; in
    // WRITE it looks for the next lane above the one being written.
    assign w_pick_mask = (r_state == DMEM_IDLE) ? req_sel_i : r_sel;
    assign w_pick_from = (r_state == DMEM_IDLE) ? 3'd0 : (r_cnt + 3'd1);

    dmem_lane_pick u_lane_pick (
        .i_mask (w_pick_mask),
        .i_from (w_pick_from),
        .o_lane (w_pick_lane),
        .o_last (w_pick_last)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_state <= DMEM_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            DMEM_IDLE: begin
                if (req_ce_i) begin
                    w_cnt_next = 3'd0;
                    if (w_is_write_req) begin
`ifdef DMEM_WRITE_SKIP_EN
                        if (w_pick_last) begin
                            w_state_next = DMEM_DONE;
                        end else begin
                            w_state_next = DMEM_WRITE;
                            w_cnt_next   = {1'b0, w_pick_lane};
                        end
`else
                        w_state_next = DMEM_WRITE;
`endif
                    end else begin
                        w_state_next = DMEM_READ;
                    end
                end
            end
            // One extra READ cycle (cnt = 4) catches the last byte coming back.
            DMEM_READ: begin
                if (r_cnt == 3'd4) begin
                    w_state_next = DMEM_DONE;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_cnt_next = r_cnt + 3'd1;
                end
            end
            DMEM_WRITE: begin
`ifdef DMEM_WRITE_SKIP_EN
                if (w_pick_last) begin
                    w_state_next = DMEM_DONE;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_cnt_next = {1'b0, w_pick_lane};
                end
`else
                if (r_cnt == 3'(DMEM_LANES - 1)) begin
                    w_state_next = DMEM_DONE;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_cnt_next = r_cnt + 3'd1;
                end
`endif
            end
            DMEM_DONE: begin
                w_state_next = DMEM_IDLE;
                w_cnt_next   = 3'd0;
            end
            default: begin
                w_state_next = DMEM_IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    // Request fields are captured once at acceptance; the RAM byte returned in
    // READ cycle cnt belongs to the address issued in cycle cnt-1. The top
    // byte is merged directly into rdata_o as the FSM heads to DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_addr   <= '0;
            r_wdata  <= ZeroWord;
            r_sel    <= '0;
            r_shadow <= 24'h0;
            r_rdata  <= ZeroWord;
        end else begin
            if ((r_state == DMEM_IDLE) && req_ce_i) begin
                r_addr  <= req_addr_i[ADDR_WIDTH-1:2];
                r_wdata <= req_wdata_i;
                r_sel   <= req_sel_i;
            end
            if (r_state == DMEM_READ) begin
                case (r_cnt)
                    3'd1:    r_shadow[7:0]   <= ram_din_i;
                    3'd2:    r_shadow[15:8]  <= ram_din_i;
                    3'd3:    r_shadow[23:16] <= ram_din_i;
                    3'd4:    r_rdata         <= {ram_din_i, r_shadow};
                    default: ;
                endcase
            end
        end
    end

    assign ready_o    = (r_state == DMEM_DONE);
    assign stall_o    = req_ce_i && !ready_o;
    assign rdata_o    = r_rdata;
    assign ram_a_o    = {r_addr, r_cnt[1:0]};
    assign ram_wr_o   = (r_state == DMEM_WRITE) && r_sel[r_cnt[1:0]];
    assign ram_dout_o = (r_state == DMEM_WRITE) ? lane_byte(r_wdata, r_cnt[1:0]) : 8'h00;

endmodule

// File: doc/dmem_byte_bridge.md
# dmem_byte_bridge

Responder for the data-memory interface driven by the MEM stage: accepts one word-level request (address, write data, byte select, write/chip enable) and serves it against a byte-wide synchronous external RAM. Word reads are assembled from four byte reads; writes are serialised into per-lane byte writes. A combinational stall output holds the pipeline until the access completes. Sits between the MEM stage and the external memory port.

## Interface
- `ADDR_WIDTH`, 17: external byte-address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_ce_i` in 1: request valid (MEM stage chip enable).
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in 32: byte address; bits [1:0] ignored for addressing.
- `req_wdata_i` in 32: write data, lane-positioned (lane k = bits [8k+7:8k]).
- `req_sel_i` in 4: write byte-lane enables; ignored for reads.
- `rdata_o` out 32: assembled read word, little-endian.
- `ready_o` out 1: completion, high for exactly one cycle.
- `stall_o` out 1: `req_ce_i && !ready_o`, combinational.
- `ram_a_o` out ADDR_WIDTH: external byte address.
- `ram_dout_o` out 8: external write byte.
- `ram_wr_o` out 1: external write strobe.
- `ram_din_i` in 8: external read byte, valid one cycle after its address.

## Operation
- States: IDLE, READ, WRITE, DONE. Lane counter `cnt` (3 bits).
- IDLE: if `req_ce_i`, latch addr/wdata/sel/we, clear `cnt`, go to READ or WRITE. Otherwise stay.
- READ, `cnt` = 0..4:
  - `ram_a_o = {addr[ADDR_WIDTH-1:2], cnt[1:0]}` for `cnt` ≤ 3.
  - For `cnt` ≥ 1, capture `ram_din_i` into byte `cnt-1` of the shadow word.
  - At `cnt` = 4, go to DONE.
  - Copy the shadow word to `rdata_o` on entry to DONE.
- WRITE, `cnt` = 0..3:
  - `ram_a_o = {addr[..:2], cnt[1:0]}`.
  - `ram_dout_o` = lane `cnt` of the latched data.
  - `ram_wr_o = sel[cnt]`.
  - After `cnt` = 3, go to DONE.
- DONE: `ready_o` = 1 for one cycle, then unconditionally return to IDLE. A new request is not accepted in the DONE cycle.
- Request inputs are sampled only at acceptance. Deasserting `req_ce_i` mid-transaction does not abort it.
- `rdata_o` holds the last read result. Writes never modify it.
- Write with `sel` = 0000: completes normally with no `ram_wr_o` pulse.
- `ram_wr_o` is 0 in every state except WRITE.

## Timing
- Reset values: state IDLE, `cnt` 0, `rdata_o` 0, `ready_o` 0, `ram_wr_o` 0, `ram_a_o` 0, `ram_dout_o` 0. `stall_o` follows `req_ce_i`.
- Reset mid-transaction: immediate return to IDLE, no `ready_o`, no further `ram_wr_o`. Partial writes already done remain in RAM.
- Read latency: accept edge, then 5 READ cycles, then DONE. `ready_o` is high in the 7th cycle counting the accept cycle as 1.
- Write latency (macro off): accept, 4 WRITE cycles, DONE. `ready_o` is high in the 6th cycle.
- Back-to-back requests: minimum 1 IDLE cycle between DONE and the next accept.
- `ram_a_o` / `ram_dout_o` / `ram_wr_o` are registered or decoded from registered state only. They never depend combinationally on `req_*`.

## Configuration
- `DMEM_WRITE_SKIP_EN`:
  - Defined: WRITE visits only lanes with `sel` = 1, jumping `cnt` to the next set lane in ascending order. Last set lane goes to DONE. `sel` = 0000 goes IDLE→DONE directly. `sel` = 0001 gives `ready_o` in cycle 3.
  - Undefined: fixed 4-cycle WRITE as described above.

## Structure
- `defines.v` holds:
  - state encodings `DMEM_IDLE`, `DMEM_READ`, `DMEM_WRITE`, `DMEM_DONE`;
  - `DMEM_LANES` = 4;
  - the existing `RstEnable` / `WriteEnable` / `ZeroWord` constants, reused.
- One sub-module, `dmem_lane_pick`: combinational next-set-lane finder (4-bit mask plus current lane → next lane and last-flag). Instantiated only under `DMEM_WRITE_SKIP_EN`.

## Test plan
- Read of 0x0000_0104 with RAM bytes [0x104..0x107] = 78,56,34,12 → `ram_a_o` 0x104..0x107 on successive cycles. `rdata_o` = 0x12345678 with `ready_o` in cycle 7. `stall_o` = 1 in cycles 1–6.
- SB-style write: addr 0x202, sel 0100, wdata 0x00AB0000 → exactly one `ram_wr_o` at `ram_a_o` 0x202 with data 0xAB. `ready_o` in cycle 6 (macro off) or cycle 3 (macro on).
- SW: addr 0x300, sel 1111, data 0xDEADBEEF, then read 0x300 → writes EF,BE,AD,DE to 0x300..0x303. The read returns 0xDEADBEEF.
- Write with sel 0000 → no `ram_wr_o`, `ready_o` still pulses once, `rdata_o` unchanged.
- `rst` low during the 2nd WRITE cycle of sel 1111 → `ram_wr_o` drops immediately. State is IDLE. No `ready_o`. Next read completes normally.
- `req_ce_i` dropped after accept of a read → transaction still completes. `ready_o` pulses. A new request is accepted only from the IDLE cycle after DONE.
